// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants for the HD44780 command sequencer. This file
//               holds the 10-bit {RS,RW,D7..D0} words, the init command ROM
//               and the sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Busy-flag read (RS=0, RW=1). Repeating it on the bus does no harm.
    localparam logic [9:0] IDLE_WORD    = 10'h100;
    localparam logic [9:0] CMD_WAKE     = 10'h033;
    localparam logic [9:0] CMD_4BIT     = 10'h032;
    localparam logic [9:0] CMD_FUNC_SET = 10'h028;
    localparam logic [9:0] CMD_ENTRY    = 10'h006;
    localparam logic [9:0] CMD_DISP_ON  = 10'h00C;
    localparam logic [9:0] CMD_CLEAR    = 10'h001;
    localparam logic [9:0] CMD_LINE1    = 10'h080;
    localparam logic [9:0] CMD_LINE2    = 10'h0C0;

    // Index of the last init ROM entry (Clear Display).
    localparam logic [2:0] INIT_LAST    = 3'd5;
    // First character index of display line 2.
    localparam logic [4:0] LINE2_BASE   = 5'd16;

    // Sequencer state encoding. The state names the word currently on data.
    localparam logic [2:0] ST_PWRUP_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT       = 3'd1;
    localparam logic [2:0] ST_CLR_WAIT   = 3'd2;
    localparam logic [2:0] ST_ADDR1      = 3'd3;
    localparam logic [2:0] ST_LINE1      = 3'd4;
    localparam logic [2:0] ST_ADDR2      = 3'd5;
    localparam logic [2:0] ST_LINE2      = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    typedef enum logic [2:0] {
        S_PWRUP_WAIT = ST_PWRUP_WAIT,
        S_INIT       = ST_INIT,
        S_CLR_WAIT   = ST_CLR_WAIT,
        S_ADDR1      = ST_ADDR1,
        S_LINE1      = ST_LINE1,
        S_ADDR2      = ST_ADDR2,
        S_LINE2      = ST_LINE2,
        S_DONE       = ST_DONE
    } seq_state_e;

    // Init command ROM. Out-of-range indices return the idle word.
    function automatic logic [9:0] init_rom(input logic [2:0] idx);
        logic [9:0] w;
        case (idx)
            3'd0:    w = CMD_WAKE;
            3'd1:    w = CMD_4BIT;
            3'd2:    w = CMD_FUNC_SET;
            3'd3:    w = CMD_ENTRY;
            3'd4:    w = CMD_DISP_ON;
            3'd5:    w = CMD_CLEAR;
            default: w = IDLE_WORD;
        endcase
        return w;
    endfunction

    // Character write: RS=1 (data register), RW=0.
    function automatic logic [9:0] char_word(input logic [7:0] c);
        return {2'b10, c};
    endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_word_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lcd_word_tracker
// Description : Registers LCD_E from the transfer FSM and detects its falling
//               edges. It also tracks which nibble of a word has just
//               finished. word_boundary_o pulses on the fall that ends the
//               lower (second) nibble.
// Revision    : 1.0  initial release
// ============================================================================
module lcd_word_tracker (
    input  logic clk,
    input  logic reset,
    input  logic lcd_e_i,
    output logic word_boundary_o
);

    logic lcd_e_q;
    logic phase_q;
    logic fall;

    assign fall            = lcd_e_q & ~lcd_e_i;
    assign word_boundary_o = fall & phase_q;

    // Delay LCD_E by one clock and toggle the nibble phase on every fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcd_e_q <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            lcd_e_q <= lcd_e_i;
            if (fall) begin
                phase_q <= ~phase_q;
            end
        end
    end

endmodule : lcd_word_tracker
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cmd_sequencer
// Description : Word source for the 4-bit HD44780 transfer FSM. It first waits
//               out the power-up delay and then issues the init commands. After
//               the post-clear wait it writes the 2x16 character buffer.
//               The output word changes only at word boundaries.
//               Optional macro LCD_SEQ_REFRESH_EN: rewrite the display
//               continuously instead of stopping after one frame.
// Revision    : 1.0  initial release
// ============================================================================
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_WAIT = 750000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int WAIT_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic [7:0] char_data,
    output logic [9:0] data,
    output logic [4:0] char_addr,
    output logic       init_done,
    output logic       frame_done
);

    localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(POWERUP_WAIT - 1);
    localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'(CLEAR_WAIT - 1);

    seq_state_e        state_q;
    logic [2:0]        idx_q;
    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;
    logic [WAIT_W-1:0] wait_last;
    logic              wait_expired;
    logic              word_boundary;

    lcd_word_tracker u_tracker (
        .clk             (clk),
        .reset           (reset),
        .lcd_e_i         (lcd_e),
        .word_boundary_o (word_boundary)
    );

    // The wait counter saturates at its terminal value. A boundary on the
    // same cycle as expiry therefore sees the wait as expired.
    always_comb begin
        wait_last    = (state_q == S_CLR_WAIT) ? CLR_LAST : PWR_LAST;
        wait_expired = (cnt_q == wait_last);
        cnt_d        = wait_expired ? cnt_q : cnt_q + 1'b1;
    end

    // Sequencer FSM. The state, data word and status flags advance only at word boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_PWRUP_WAIT;
            idx_q      <= 3'd0;
            cnt_q      <= '0;
            data       <= IDLE_WORD;
            char_addr  <= 5'd0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state_q == S_PWRUP_WAIT || state_q == S_CLR_WAIT) begin
                cnt_q <= cnt_d;
            end
            if (word_boundary) begin
                case (state_q)
                    S_PWRUP_WAIT: begin
                        if (wait_expired) begin
                            state_q <= S_INIT;
                            idx_q   <= 3'd0;
                            data    <= init_rom(3'd0);
                        end
                    end
                    S_INIT: begin
                        if (idx_q == INIT_LAST) begin
                            // Clear Display has gone out. Poll busy until the wait ends.
                            state_q <= S_CLR_WAIT;
                            data    <= IDLE_WORD;
                            cnt_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            data  <= init_rom(idx_q + 3'd1);
                        end
                    end
                    S_CLR_WAIT: begin
                        if (wait_expired) begin
                            state_q   <= S_ADDR1;
                            data      <= CMD_LINE1;
                            init_done <= 1'b1;
                        end
                    end
                    S_ADDR1: begin
                        state_q   <= S_LINE1;
                        data      <= char_word(char_data);
                        char_addr <= char_addr + 5'd1;
                    end
                    S_LINE1: begin
                        if (char_addr == LINE2_BASE) begin
                            state_q <= S_ADDR2;
                            data    <= CMD_LINE2;
                        end else begin
                            data      <= char_word(char_data);
                            char_addr <= char_addr + 5'd1;
                        end
                    end
                    S_ADDR2: begin
                        state_q   <= S_LINE2;
                        data      <= char_word(char_data);
                        char_addr <= char_addr + 5'd1;
                    end
                    S_LINE2: begin
                        if (char_addr == 5'd0) begin
                            // char_addr has wrapped. Character 31 has just finished.
                            frame_done <= 1'b1;
`ifdef LCD_SEQ_REFRESH_EN
                            state_q    <= S_ADDR1;
                            data       <= CMD_LINE1;
`else
                            state_q    <= S_DONE;
                            data       <= IDLE_WORD;
`endif
                        end else begin
                            data      <= char_word(char_data);
                            char_addr <= char_addr + 5'd1;
                        end
                    end
                    S_DONE: begin
                        data <= IDLE_WORD;
                    end
                    default: begin
                        state_q <= S_PWRUP_WAIT;
                        data    <= IDLE_WORD;
                    end
                endcase
            end
        end
    end

endmodule : lcd_cmd_sequencer
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_cmd_sequencer
// Description : Self-checking bench for lcd_cmd_sequencer. It drives LCD_E the
//               way the 4-bit transfer FSM would and serves the character
//               buffer. It compares every output against a script-position
//               model of the display session.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_cmd_sequencer;

    localparam int PW = 50;
    localparam int CW = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lcd_e = 1'b0;
    logic [7:0] char_data;
    logic [9:0] data;
    logic [4:0] char_addr;
    logic       init_done;
    logic       frame_done;

    logic [7:0] cbuf [0:31];

    int n_cmp = 0;
    int n_bad = 0;
    int dut_fd_cnt = 0;

    always #5 clk = ~clk;

    always_comb char_data = cbuf[char_addr];

    lcd_cmd_sequencer #(
        .POWERUP_WAIT (PW),
        .CLEAR_WAIT   (CW),
        .WAIT_W       (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_e      (lcd_e),
        .char_data  (char_data),
        .data       (data),
        .char_addr  (char_addr),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    // ------------------------------------------------------------------
    // Reference model. m_pos is the position in the session script:
    //  -1 power-up wait, 0..5 init commands, 6 clear wait, 7 line-1 address,
    //  8..23 line-1 chars, 24 line-2 address, 25..40 line-2 chars, 41 done.
    // ------------------------------------------------------------------
    function automatic logic [9:0] init_cmd(input int i);
        case (i)
            0: return 10'h033;
            1: return 10'h032;
            2: return 10'h028;
            3: return 10'h006;
            4: return 10'h00C;
            default: return 10'h001;
        endcase
    endfunction

    int         m_pos;
    int         m_k;
    logic       m_e_q;
    logic       m_ph;
    logic [9:0] m_word;
    logic [4:0] m_addr;
    logic       m_init;
    logic       m_fd;
    int         m_fd_cnt;
    logic       m_fall, m_bnd;
    int         m_k1;
    logic       m_is_char_load;

    assign m_fall = m_e_q & ~lcd_e;
    assign m_bnd  = m_fall & m_ph;
    assign m_k1   = m_k + 1;
    assign m_is_char_load = (m_pos == 7) || (m_pos >= 8 && m_pos < 23) ||
                            (m_pos == 24) || (m_pos >= 25 && m_pos < 40);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pos <= -1; m_k <= 0; m_e_q <= 1'b0; m_ph <= 1'b0;
            m_word <= 10'h100; m_addr <= 5'd0; m_init <= 1'b0; m_fd <= 1'b0;
            m_fd_cnt <= 0;
        end else begin
            m_e_q <= lcd_e;
            if (m_fall) m_ph <= ~m_ph;
            m_fd <= 1'b0;
            m_k  <= m_k1;
            if (m_bnd) begin
                if (m_pos == -1) begin
                    if (m_k1 >= PW) begin m_pos <= 0; m_word <= init_cmd(0); end
                end else if (m_pos <= 4) begin
                    m_pos <= m_pos + 1; m_word <= init_cmd(m_pos + 1);
                end else if (m_pos == 5) begin
                    m_pos <= 6; m_word <= 10'h100; m_k <= 0;
                end else if (m_pos == 6) begin
                    if (m_k1 >= CW) begin m_pos <= 7; m_word <= 10'h080; m_init <= 1'b1; end
                end else if (m_is_char_load) begin
                    m_pos  <= m_pos + 1;
                    m_word <= {2'b10, cbuf[m_addr]};
                    m_addr <= m_addr + 5'd1;
                end else if (m_pos == 23) begin
                    m_pos <= 24; m_word <= 10'h0C0;
                end else if (m_pos == 40) begin
                    m_fd <= 1'b1; m_fd_cnt <= m_fd_cnt + 1;
`ifdef LCD_SEQ_REFRESH_EN
                    m_pos <= 7; m_word <= 10'h080;
`else
                    m_pos <= 41; m_word <= 10'h100;
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers (all called from the single stimulus process)
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (frame_done === 1'b1) dut_fd_cnt++;
        chk("data", 32'(data), 32'(m_word));
        chk("char_addr", 32'(char_addr), 32'(m_addr));
        chk("init_done", 32'(init_done), 32'(m_init));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic nibble(input int hi, input int lo);
        lcd_e = 1'b1;
        repeat (hi) tick();
        lcd_e = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic word_xfer(input int gap, input int hi, input int lo);
        repeat (gap) tick();
        nibble(hi, lo);
        nibble(hi, lo);
    endtask

    task automatic rand_word(input int max_gap);
        cbuf[$urandom_range(31, 0)] = 8'($urandom);
        word_xfer(int'($urandom_range(max_gap, 0)), int'($urandom_range(3, 1)),
                  int'($urandom_range(3, 1)));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'h100);
        chk("rst_char_addr", 32'(char_addr), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b1;
    endtask

    typedef struct {
        int         gap;
        logic [9:0] exp_data;
        logic [4:0] exp_addr;
        logic       exp_init;
    } vec_t;

    vec_t vecs [27];

    initial begin
        int guard;
        // Table: one word transfer per record, then check the loaded word.
        vecs[0] = '{gap: 2,  exp_data: 10'h100, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[1] = '{gap: 60, exp_data: 10'h033, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[2] = '{gap: 1,  exp_data: 10'h032, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[3] = '{gap: 1,  exp_data: 10'h028, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[4] = '{gap: 1,  exp_data: 10'h006, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[5] = '{gap: 1,  exp_data: 10'h00C, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[6] = '{gap: 1,  exp_data: 10'h001, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[7] = '{gap: 1,  exp_data: 10'h100, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[8] = '{gap: 1,  exp_data: 10'h100, exp_addr: 5'd0, exp_init: 1'b0};
        vecs[9] = '{gap: 40, exp_data: 10'h080, exp_addr: 5'd0, exp_init: 1'b1};
        for (int i = 0; i < 16; i++) begin
            vecs[10 + i] = '{gap: 0, exp_data: 10'(10'h241 + i),
                             exp_addr: 5'(i + 1), exp_init: 1'b1};
        end
        vecs[26] = '{gap: 0, exp_data: 10'h0C0, exp_addr: 5'd16, exp_init: 1'b1};

        for (int i = 0; i < 32; i++) cbuf[i] = (i < 16) ? 8'(8'h41 + i) : 8'(8'h61 + i - 16);

        // Phase 1: deterministic init and line-1 write
        apply_reset();
        for (int i = 0; i < 27; i++) begin
            word_xfer(vecs[i].gap, 2, 1);
            chk($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_addr", i), 32'(char_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_init", i), 32'(init_done), 32'(vecs[i].exp_init));
        end

        // Phase 2: random timing and buffer changes through line 2 and past frame end
        for (int i = 0; i < 40; i++) rand_word(4);
        chk("frame_pulses_vs_model", 32'(dut_fd_cnt), 32'(m_fd_cnt));
`ifndef LCD_SEQ_REFRESH_EN
        chk("frame_pulses_once", 32'(dut_fd_cnt), 32'd1);
        chk("done_data_idle", 32'(data), 32'h100);
        chk("done_addr_zero", 32'(char_addr), 32'd0);
`endif

        // Phase 3: asynchronous reset while line-1 character 7 is on the bus
        apply_reset();
        word_xfer(55, 1, 1);
        guard = 0;
        while (m_pos != 15 && guard < 200) begin
            rand_word(35);
            guard++;
        end
        chk("reach_line1_char7", 32'(m_pos), 32'd15);
        chk("pre_reset_init_done", 32'(init_done), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_data", 32'(data), 32'h100);
        chk("async_rst_char_addr", 32'(char_addr), 32'd0);
        chk("async_rst_init_done", 32'(init_done), 32'd0);
        lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Phase 4: full re-run from power-up with wide random gaps
        for (int i = 0; i < 70; i++) rand_word(40);
        chk("rerun_init_done", 32'(init_done), 32'(m_init));
        chk("rerun_frame_pulses", 32'(dut_fd_cnt), 32'(m_fd_cnt + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lcd_cmd_sequencer
`default_nettype wire
